// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul tile sequencer.
package matmul_pkg;

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, WRITE, FIN} state_t;

  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 7;
  localparam int TILE_DEF   = 4;

  // Cycles the array needs after the last operand enters before C is valid.
  function automatic int drain_cycles(input int tile, input int mac_lat,
                                      input int grid_r, input int grid_c);
    return mac_lat * tile + tile + grid_r + grid_c - 2;
  endfunction

endpackage

// File: rtl/skew_addr_gen.sv
// One bank's operand address generator; OFFSET is the bank's systolic skew in cycles.
module skew_addr_gen #(
  parameter int AWIDTH = 7,
  parameter int CNT_W  = 16,
  parameter int OFFSET = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              feed,
  input  logic              host,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [AWIDTH:0]   len,
  input  logic [AWIDTH-1:0] host_addr,
  output logic              en,
  output logic [AWIDTH-1:0] addr
);

  logic [CNT_W-1:0]  rel;
  logic              in_win;
  logic              en_d;
  logic [AWIDTH-1:0] addr_d;

  always_comb begin
    rel    = cnt - CNT_W'(OFFSET);
    in_win = (cnt >= CNT_W'(OFFSET)) && (rel < CNT_W'(len));
    en_d   = feed && in_win;
    addr_d = '0;
    if (host) begin
      addr_d = host_addr;
    end else if (en_d) begin
      addr_d = rel[AWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en   <= 1'b0;
      addr <= '0;
    end else begin
      en   <= en_d;
      addr <= addr_d;
    end
  end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Sequences one matmul pass over a GRID_R x GRID_C systolic tile array: feed, drain, write-back.
module matmul_tile_sequencer
  import matmul_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int TILE    = TILE_DEF,
  parameter int GRID_R  = 2,
  parameter int GRID_C  = 2,
  parameter int MAC_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               k_tiles,
  input  logic                     host_wr_en,
  input  logic                     host_rd_en,
  input  logic [AWIDTH-1:0]        host_addr,
  output logic [GRID_R*AWIDTH-1:0] a_addr,
  output logic [GRID_R-1:0]        a_en,
  output logic [GRID_C*AWIDTH-1:0] b_addr,
  output logic [GRID_C-1:0]        b_en,
  output logic [AWIDTH-1:0]        c_addr,
  output logic                     c_we,
  output logic                     clear_acc,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int GRID_MAX  = (GRID_R > GRID_C) ? GRID_R : GRID_C;
  localparam int DRAIN_LEN = drain_cycles(TILE, MAC_LAT, GRID_R, GRID_C);
  localparam int CNT_W     = 16;

  if (DWIDTH < 1 || AWIDTH < 1 || AWIDTH + 1 > CNT_W || TILE < 1 ||
      GRID_R < 1 || GRID_C < 1 || MAC_LAT < 1) begin : g_bad_param
    $error("matmul_tile_sequencer: unsupported parameter combination");
  end

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [AWIDTH:0]   len, len_nx;
  logic [CNT_W-1:0]  feed_last;
  logic [31:0]       k_len;
  logic              host_req;
  logic              host_mode;
  logic              accept;
  logic              err_nx;

  logic              feed_d;
  logic              busy_d;
  logic              done_d;
  logic              c_we_d;
  logic [AWIDTH-1:0] c_addr_d;

  assign host_req  = host_wr_en | host_rd_en;
  assign k_len     = 32'(k_tiles) * 32'(TILE);
  assign feed_last = CNT_W'(len) + CNT_W'(GRID_MAX) - CNT_W'(2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      len   <= len_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    len_nx    = len;
    accept    = 1'b0;
    host_mode = 1'b0;
    err_nx    = err;
    // Host traffic during a pass is only flagged; it never touches the sequence.
    if (state != IDLE && host_req) err_nx = 1'b1;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (host_req) begin
          host_mode = 1'b1;
          if (start) err_nx = 1'b1;
        end else if (start) begin
          if (k_tiles != 8'd0 && k_len <= 32'(2 ** AWIDTH)) begin
            accept   = 1'b1;
            state_nx = FEED;
            len_nx   = k_len[AWIDTH:0];
            err_nx   = 1'b0;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      FEED: begin
        if (cnt == feed_last) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(DRAIN_LEN - 1)) begin
          state_nx = WRITE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WRITE: begin
        if (cnt == CNT_W'(TILE - 1)) begin
          state_nx = FIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      FIN: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered value lines up with that state.
  always_comb begin
    feed_d   = (state_nx == FEED);
    busy_d   = (state_nx == FEED) || (state_nx == DRAIN) || (state_nx == WRITE);
    done_d   = (state_nx == FIN);
    c_we_d   = (state_nx == WRITE);
    c_addr_d = '0;
    if (host_mode) begin
      c_addr_d = host_addr;
    end else if (state_nx == WRITE) begin
      c_addr_d = cnt_nx[AWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_addr    <= '0;
      c_we      <= 1'b0;
      clear_acc <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      c_addr    <= c_addr_d;
      c_we      <= c_we_d;
      clear_acc <= accept;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_nx;
    end
  end

  for (genvar r = 0; r < GRID_R; r++) begin : g_a_bank
    skew_addr_gen #(.AWIDTH(AWIDTH), .CNT_W(CNT_W), .OFFSET(r)) u_gen (
      .clk       (clk),
      .reset     (reset),
      .feed      (feed_d),
      .host      (host_mode),
      .cnt       (cnt_nx),
      .len       (len_nx),
      .host_addr (host_addr),
      .en        (a_en[r]),
      .addr      (a_addr[r*AWIDTH +: AWIDTH])
    );
  end

  for (genvar c = 0; c < GRID_C; c++) begin : g_b_bank
    skew_addr_gen #(.AWIDTH(AWIDTH), .CNT_W(CNT_W), .OFFSET(c)) u_gen (
      .clk       (clk),
      .reset     (reset),
      .feed      (feed_d),
      .host      (host_mode),
      .cnt       (cnt_nx),
      .len       (len_nx),
      .host_addr (host_addr),
      .en        (b_en[c]),
      .addr      (b_addr[c*AWIDTH +: AWIDTH])
    );
  end

endmodule
